// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, whole-line refill
// through word reads on a miss, one fetch request outstanding at a time.
module icache #(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned WOFF_W  = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              iIF_En,
  input  logic [ADDR_W-1:0] iIF_Pc,
  output logic              oIF_En,
  output logic [31:0]       oIF_Ins,
  output logic              oMC_En,
  output logic [ADDR_W-1:0] oMC_Addr,
  input  logic              iMC_En,
  input  logic [31:0]       iMC_Dat
);

  localparam int unsigned LINES   = 1 << INDEX_W;
  localparam int unsigned WORDS   = 1 << WOFF_W;
  localparam int unsigned IDX_LSB = 2 + WOFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + INDEX_W;
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WOFF_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:2]   pc_q, pc_d;
  logic [31:0]         pend_q, pend_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic [31:0]         data_q [LINES][WORDS];

  logic                if_en_d;
  logic [31:0]         ins_d;
  logic                mc_en_d;
  logic [ADDR_W-1:0]   mc_addr_d;
  logic                miss_alloc;
  logic                fill_we;
  logic                fill_done;

  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [WOFF_W-1:0]   req_off;
  logic                req_hit;
  logic [INDEX_W-1:0]  line_idx;
  logic [WOFF_W-1:0]   pc_off;
  logic                unused_pc_lsbs;

  // Address split of the incoming request and of the latched miss PC
  assign req_idx        = iIF_Pc[TAG_LSB-1:IDX_LSB];
  assign req_tag        = iIF_Pc[ADDR_W-1:TAG_LSB];
  assign req_off        = iIF_Pc[IDX_LSB-1:2];
  assign req_hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign line_idx       = pc_q[TAG_LSB-1:IDX_LSB];
  assign pc_off         = pc_q[IDX_LSB-1:2];
  assign unused_pc_lsbs = ^iIF_Pc[1:0];

  // Next-state and registered-output values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    if_en_d    = 1'b0;
    ins_d      = oIF_Ins;
    mc_en_d    = 1'b0;
    mc_addr_d  = oMC_Addr;
    miss_alloc = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (iIF_En) begin
          pc_d = iIF_Pc[ADDR_W-1:2];
          if (req_hit) begin
            if_en_d = 1'b1;
            ins_d   = data_q[req_idx][req_off];
          end else begin
            miss_alloc = 1'b1;
            cnt_d      = '0;
            state_d    = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        mc_en_d   = 1'b1;
        mc_addr_d = {pc_q[ADDR_W-1:IDX_LSB], cnt_q, 2'b00};
        state_d   = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (iMC_En) begin
          fill_we = 1'b1;
          if (cnt_q == pc_off) begin
            pend_d = iMC_Dat;
          end
          // Last-word check happens before any increment, so the counter never wraps early
          if (cnt_q == LAST_WORD) begin
            fill_done = 1'b1;
            if_en_d   = 1'b1;
            ins_d     = (cnt_q == pc_off) ? iMC_Dat : pend_q;
            state_d   = IDLE;
          end else begin
            cnt_d   = cnt_q + WOFF_W'(1);
            state_d = MISS_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid bits and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pc_q     <= '0;
      pend_q   <= '0;
      valid_q  <= '0;
      oIF_En   <= 1'b0;
      oIF_Ins  <= '0;
      oMC_En   <= 1'b0;
      oMC_Addr <= '0;
    end else if (en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      oIF_En   <= if_en_d;
      oIF_Ins  <= ins_d;
      oMC_En   <= mc_en_d;
      oMC_Addr <= mc_addr_d;
      if (miss_alloc) valid_q[req_idx] <= 1'b0;
      if (fill_done)  valid_q[line_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are only meaningful under their valid bit, so they need no reset
  always_ff @(posedge clk) begin
    if (!rst && en) begin
      if (miss_alloc) tag_q[req_idx] <= req_tag;
      if (fill_we)    data_q[line_idx][cnt_q] <= iMC_Dat;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: reference cache/memory model feeds expectation queues,
// a monitor checks responses and refill requests, a memory model answers reads.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        iIF_En;
  logic [31:0] iIF_Pc;
  logic        oIF_En;
  logic [31:0] oIF_Ins;
  logic        oMC_En;
  logic [31:0] oMC_Addr;
  logic        iMC_En;
  logic [31:0] iMC_Dat;

  always #5 clk = ~clk;

  icache dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .iIF_En   (iIF_En),
    .iIF_Pc   (iIF_Pc),
    .oIF_En   (oIF_En),
    .oIF_Ins  (oIF_Ins),
    .oMC_En   (oMC_En),
    .oMC_Addr (oMC_Addr),
    .iMC_En   (iMC_En),
    .iMC_Dat  (iMC_Dat)
  );

  typedef struct {
    logic [31:0] ins;
    bit          hit;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mc_exp_q[$];
  logic [31:0] mc_pend[$];

  int checks = 0;
  int fails  = 0;
  int cyc = 0, issue_cyc = 0, last_mc_cyc = 0, mc_done = 0;
  bit rand_en = 0, stall_req = 0;

  // Reference cache state: which line (by tag) each index holds
  bit          m_valid [32];
  logic [22:0] m_tag   [32];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F69;
    endcase
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: one pass per enabled clock edge, just after the edge
  always @(posedge clk) begin
    #1;
    if (!rst && en) begin
      exp_t e;
      cyc++;
      if (iIF_En) issue_cyc = cyc;
      if (iMC_En) begin
        last_mc_cyc = cyc;
        mc_done++;
      end
      if (oMC_En) begin
        check("mc_req_expected", 32'(mc_exp_q.size() != 0), 32'd1);
        if (mc_exp_q.size() != 0) check("mc_addr", oMC_Addr, mc_exp_q.pop_front());
        mc_pend.push_back(oMC_Addr);
      end
      if (oIF_En) begin
        check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ins", oIF_Ins, e.ins);
          if (e.hit) begin
            check("hit_latency", 32'(cyc + 1 - issue_cyc), 32'd1);
          end else begin
            check("miss_latency", 32'(cyc + 1 - last_mc_cyc), 32'd1);
            check("line_complete", 32'(mc_exp_q.size()), 32'd0);
          end
        end
      end
    end
  end

  // Memory controller model: answers each read after a random delay, gated by en
  initial begin
    int delay;
    logic [31:0] a;
    iMC_En  = 1'b0;
    iMC_Dat = '0;
    delay   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mc_pend.delete();
      end else if (mc_pend.size() != 0) begin
        if (delay > 0) begin
          delay--;
        end else begin
          a       = mc_pend.pop_front();
          iMC_En  = 1'b1;
          iMC_Dat = mem_word(a);
          do @(posedge clk); while (!en && !rst);
          @(negedge clk);
          iMC_En  = 1'b0;
          iMC_Dat = $urandom;
          delay   = int'($urandom_range(0, 2));
          if (rst) mc_pend.delete();
        end
      end
    end
  end

  // Global ready: forced low for stalls, optionally randomised
  initial begin
    en = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (stall_req)    en = 1'b0;
      else if (rand_en) en = ($urandom_range(0, 3) != 0);
      else              en = 1'b1;
    end
  end

  task automatic do_fetch(input logic [31:0] pc, input bit wait_resp);
    int  idx;
    bit  hit;
    int  n;
    idx = int'(pc[8:4]);
    hit = m_valid[idx] && (m_tag[idx] == pc[31:9]);
    if (!hit) begin
      for (int w = 0; w < 4; w++) mc_exp_q.push_back((pc & 32'hFFFF_FFF0) + 32'(w * 4));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = pc[31:9];
    end
    exp_q.push_back('{ins: mem_word(pc), hit: hit});
    @(negedge clk);
    iIF_Pc = pc;
    iIF_En = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!en && n < 1000);
    @(negedge clk);
    iIF_En = 1'b0;
    iIF_Pc = $urandom;
    if (wait_resp) wait_idle();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mc_exp_q.size() != 0) && n < 400) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 400) begin
      checks++;
      fails++;
      $display("FAIL timeout: pending_resp=%0d pending_reads=%0d, expected 0", exp_q.size(), mc_exp_q.size());
      exp_q.delete();
      mc_exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oIF_En"},   32'(oIF_En),  32'd0);
    check({tag, "_oIF_Ins"},  oIF_Ins,      32'd0);
    check({tag, "_oMC_En"},   32'(oMC_En),  32'd0);
    check({tag, "_oMC_Addr"}, oMC_Addr,     32'd0);
  endtask

  initial begin
    bit          found;
    int          base;
    logic [31:0] held_addr;
    logic        held_mc_en;
    logic [31:0] pc;

    rst    = 1'b1;
    iIF_En = 1'b0;
    iIF_Pc = '0;
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Cold miss, hit after fill, mid-line miss, conflict eviction
    do_fetch(32'h0, 1);
    do_fetch(32'h8, 1);
    do_fetch(32'h10C, 1);
    do_fetch(32'h200, 1);
    do_fetch(32'h0, 1);
    do_fetch(32'hC, 1);
    do_fetch(32'h104, 1);

    // Stall with a read word held on the bus
    do_fetch(32'h404, 0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (iMC_En) begin
        found = 1'b1;
        break;
      end
    end
    check("stall_word_seen", 32'(found), 32'd1);
    held_addr  = oMC_Addr;
    held_mc_en = oMC_En;
    stall_req  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #3;
      check("stall_oIF_En", 32'(oIF_En), 32'd0);
      check("stall_oMC_En_hold", 32'(oMC_En), 32'(held_mc_en));
      check("stall_oMC_Addr_hold", oMC_Addr, held_addr);
    end
    stall_req = 1'b0;
    wait_idle();

    // Reset after two of four refill words
    do_fetch(32'h608, 0);
    base  = mc_done;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mc_done >= base + 2) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_two_words", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    exp_q.delete();
    mc_exp_q.delete();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    repeat (8) @(posedge clk);
    do_fetch(32'h608, 1);
    do_fetch(32'h104, 1);
    do_fetch(32'h600, 1);

    // Randomised traffic over a few conflicting tags with random global ready
    rand_en = 1'b1;
    for (int t = 0; t < 80; t++) begin
      pc = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
      do_fetch(pc, 1);
    end
    rand_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("final_resp_queue", 32'(exp_q.size()), 32'd0);
    check("final_read_queue", 32'(mc_exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
